// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if -- pop-side handshake bundle of the UART receive FIFO.
//
// Signals:
//   rx_data  : FIFO head byte, meaningful while rx_valid=1
//   rx_valid : FIFO non-empty
//   rx_ready : consumer pops the head on rx_valid & rx_ready
//   rx_count : FIFO occupancy, 0..FIFO_DEPTH
//
// Modports:
//   master : the receiver (drives data/valid/count, samples ready)
//   slave  : the consumer (samples data/valid/count, drives ready)
interface uart_rx_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [CW-1:0] rx_count;

   modport master (output rx_data, output rx_valid, output rx_count, input rx_ready);
   modport slave  (input rx_data, input rx_valid, input rx_count, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- UART receive front end with a first-word-fall-through FIFO.
//
// Synchronises the raw rx pad, validates start bits, samples each frame
// at mid-bit and queues good bytes. Frame/overrun/parity errors are
// single-cycle pulses; irq is high while data is pending.
//
// Build option: define UART_RX_PARITY_EN for 8E1 frames (even parity,
// bytes with bad parity are discarded). Undefined: 8N1, parity_err = 0.
//
// Ports:
//   wb_clk_i    : clock
//   wb_rst_i    : synchronous active-high reset
//   rx          : raw asynchronous serial input, idle high
//   bus         : pop handshake (rx_data/rx_valid/rx_ready/rx_count)
//   frame_err   : pulse, stop bit sampled 0
//   overrun_err : pulse, good byte dropped because the FIFO was full
//   parity_err  : pulse, parity mismatch
//   irq         : level, equals rx_valid
module uart_rx_fifo #(
   parameter int CLK_PER_BIT = 87,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_i,
   input  logic           rx,
   uart_rx_fifo_if.master bus,
   output logic           frame_err,
   output logic           overrun_err,
   output logic           parity_err,
   output logic           irq
);
   localparam int TW = $clog2(CLK_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [TW-1:0] T_HALF  = TW'(CLK_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] T_FULL  = TW'(CLK_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   // synchroniser
   logic sync1_q, sync1_d;
   logic rx_s_q, rx_s_d;

   // receiver
   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          frame_err_q, frame_err_d;
   logic          push;
   logic          tick;

   // fifo
   logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
   logic [AW-1:0]              wr_q, wr_d;
   logic [AW-1:0]              rd_q, rd_d;
   logic [AW:0]                count_q, count_d;
   logic                       overrun_q, overrun_d;
   logic                       pop, full, do_push;

`ifdef UART_RX_PARITY_EN
   logic par_bad_q, par_bad_d;
   logic parity_err_q, parity_err_d;
`endif

   assign sync1_d = rx;
   assign rx_s_d  = sync1_q;
   assign tick    = (timer_q == '0);

   // Receive FSM. The timer free-runs down to zero and is reloaded on
   // every transition, including each data-bit step.
   always_comb begin
      state_d     = state_q;
      timer_d     = tick ? timer_q : timer_q - TW'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d = S_START;
               timer_d = T_HALF;
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_s_q) begin
                  state_d = S_IDLE;       // glitch shorter than half a bit
               end else begin
                  state_d   = S_DATA;
                  bit_idx_d = 3'd0;
                  timer_d   = T_FULL;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               timer_d   = T_FULL;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               par_bad_d = rx_s_q ^ (^shift_q);
               state_d   = S_STOP;
               timer_d   = T_FULL;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad_q) parity_err_d = 1'b1;
                  else           push         = 1'b1;
`else
                  push = 1'b1;
`endif
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;  // one error per held-low line
               end
            end
         end
         S_BREAK: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO. A pop in the push cycle frees the slot, so a full FIFO accepts
   // the byte without overrun.
   always_comb begin
      pop       = (count_q != '0) && bus.rx_ready;
      full      = (count_q == DEPTH_C);
      do_push   = push && (!full || pop);
      overrun_d = push && full && !pop;
      mem_d     = mem_q;
      if (do_push) mem_d[wr_q] = shift_q;
      wr_d      = wr_q + AW'(do_push);
      rd_d      = rd_q + AW'(pop);
      count_d   = count_q + (AW + 1)'(do_push) - (AW + 1)'(pop);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= S_IDLE;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         mem_q       <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         count_q     <= '0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync1_q     <= sync1_d;
         rx_s_q      <= rx_s_d;
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         mem_q       <= mem_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         count_q     <= count_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign bus.rx_data  = mem_q[rd_q];
   assign bus.rx_valid = (count_q != '0);
   assign bus.rx_count = count_q;
   assign irq          = (count_q != '0);
   assign frame_err    = frame_err_q;
   assign overrun_err  = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err   = parity_err_q;
`else
   assign parity_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo -- directed + randomized bench for uart_rx_fifo.
// The reference model is a byte queue plus expected error counts, updated
// per frame from the frame's contents (good / bad stop / bad parity / full).
module tb_uart_rx_fifo;
   localparam int CPB   = 16;
   localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   // cycles from driving the start edge to the stop-bit sample cycle
   localparam int STOP_SMP = 2 + CPB / 2 + (9 + PAR) * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic ferr, oerr, perr, irq;

   uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .rx          (rx),
      .bus         (bus.master),
      .frame_err   (ferr),
      .overrun_err (oerr),
      .parity_err  (perr),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   int nvec = 0, nfail = 0;
   int n_ferr = 0, n_oerr = 0, n_perr = 0;
   int exp_ferr = 0, exp_oerr = 0, exp_perr = 0;
   logic [7:0] model_q[$];

   always @(negedge clk) begin
      if (ferr) n_ferr <= n_ferr + 1;
      if (oerr) n_oerr <= n_oerr + 1;
      if (perr) n_perr <= n_perr + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_raw(input logic [7:0] b, input logic stop_b, input logic par_flip);
      logic [10:0] fr;
      if (PAR == 1) fr = {stop_b, (^b) ^ par_flip, b, 1'b0};
      else          fr = {1'b1, stop_b, b, 1'b0};
      for (int i = 0; i < 10 + PAR; i++) begin
         rx = fr[i];
         tick(CPB);
      end
   endtask

   // send a frame and account for its outcome in the model
   task automatic model_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
      send_raw(b, stop_b, par_flip);
      if (!stop_b)                        exp_ferr++;
      else if (PAR == 1 && par_flip)      exp_perr++;
      else if (model_q.size() == DEPTH)   exp_oerr++;
      else                                model_q.push_back(b);
   endtask

   task automatic pop_chk(input logic [7:0] exp);
      chk("pop_valid", bus.rx_valid, 1);
      chk("pop_data", bus.rx_data, exp);
      bus.rx_ready = 1'b1;
      tick(1);
      bus.rx_ready = 1'b0;
   endtask

   task automatic drain();
      while (model_q.size() != 0) pop_chk(model_q.pop_front());
      chk("drain_count", bus.rx_count, 0);
      chk("drain_irq", irq, 0);
   endtask

   task automatic chk_errs(input string tag);
      chk({tag, "_ferr"}, n_ferr, exp_ferr);
      chk({tag, "_oerr"}, n_oerr, exp_oerr);
      chk({tag, "_perr"}, n_perr, exp_perr);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int k;
      bus.rx_ready = 1'b0;

      // reset state
      tick(3);
      chk("rst_data", bus.rx_data, 0);
      chk("rst_valid", bus.rx_valid, 0);
      chk("rst_count", bus.rx_count, 0);
      chk("rst_irq", irq, 0);
      chk("rst_perr", perr, 0);
      chk("rst_ferr_oerr", {ferr, oerr}, 0);
      rst = 1'b0;
      tick(2);

      // single byte with exact valid timing
      fork
         send_raw(8'hA5, 1'b1, 1'b0);
         begin
            tick(STOP_SMP);
            chk("single_valid_early", bus.rx_valid, 0);
            tick(1);
            chk("single_valid", bus.rx_valid, 1);
            chk("single_data", bus.rx_data, 8'hA5);
            chk("single_count", bus.rx_count, 1);
            chk("single_irq", irq, 1);
         end
      join
      model_q.push_back(8'hA5);
      tick(4);
      drain();

      // glitch shorter than half a bit
      rx = 1'b0;
      tick(6);
      rx = 1'b1;
      tick(3 * CPB);
      chk("glitch_count", bus.rx_count, 0);
      chk_errs("glitch");
      model_frame(8'h3C, 1'b1, 1'b0);
      tick(CPB);
      drain();

      // framing error followed by a long break
      model_frame(8'h81, 1'b0, 1'b0);
      tick(40 * CPB);
      rx = 1'b1;
      tick(CPB);
      chk("break_count", bus.rx_count, 0);
      chk_errs("break");
      model_frame(8'h55, 1'b1, 1'b0);
      tick(CPB);
      drain();

      // overrun on the 9th back-to-back byte
      for (int i = 0; i < 9; i++) model_frame(8'(i), 1'b1, 1'b0);
      tick(CPB);
      chk("ovr_count", bus.rx_count, 8);
      chk("ovr_pulses", n_oerr, 1);
      chk_errs("ovr");
      drain();

      // full FIFO, pop in the same cycle as the push of 0x99
      for (int i = 0; i < DEPTH; i++) model_frame(8'($urandom), 1'b1, 1'b0);
      fork
         send_raw(8'h99, 1'b1, 1'b0);
         begin
            tick(STOP_SMP);
            chk("fullpop_head", bus.rx_data, model_q[0]);
            bus.rx_ready = 1'b1;
            tick(1);
            bus.rx_ready = 1'b0;
            chk("fullpop_count", bus.rx_count, 8);
         end
      join
      void'(model_q.pop_front());
      model_q.push_back(8'h99);
      tick(CPB);
      chk_errs("fullpop");
      drain();

      // reset in the middle of a frame with data queued
      model_frame(8'($urandom), 1'b1, 1'b0);
      model_frame(8'($urandom), 1'b1, 1'b0);
      rx = 1'b0;
      tick(CPB);
      rx = 1'b1;
      tick(CPB);
      rx = 1'b0;
      tick(CPB);
      rx = 1'b1;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      model_q.delete();
      chk("midrst_count", bus.rx_count, 0);
      chk("midrst_valid", bus.rx_valid, 0);
      chk("midrst_data", bus.rx_data, 0);
      tick(2 * CPB);
      model_frame(8'($urandom), 1'b1, 1'b0);
      tick(CPB);
      chk_errs("midrst");
      drain();

`ifdef UART_RX_PARITY_EN
      // 0x03 has even data parity 0: parity bit 1 is an error
      model_frame(8'h03, 1'b1, 1'b1);
      tick(CPB);
      chk("par_bad_count", bus.rx_count, 0);
      chk("par_bad_pulse", n_perr, 1);
      model_frame(8'h03, 1'b1, 1'b0);
      tick(CPB);
      chk_errs("par");
      drain();
`endif

      // randomized frames, gaps and pops
      for (int it = 0; it < 24; it++) begin
         b = 8'($urandom);
         k = $urandom_range(0, 9);
         model_frame(b, k != 0, k == 1);
         rx = 1'b1;
         tick($urandom_range(4, 20));
         chk("rand_count", bus.rx_count, model_q.size());
         k = $urandom_range(0, 2);
         for (int p = 0; p < k && model_q.size() != 0; p++) pop_chk(model_q.pop_front());
      end
      chk_errs("rand");
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive front end for the user-area UART, feeding received bytes to the Wishbone-side UART register logic. It synchronises the raw `rx` pad input and detects and validates start bits. It samples 8N1 frames at mid-bit and queues good bytes in a first-word-fall-through FIFO with a valid/ready pop interface. Framing, overrun and (optionally) parity errors are reported as single-cycle pulses, and a level interrupt is raised while data is pending.

## Interface
- `CLK_PER_BIT`, default 87: `wb_clk_i` cycles per bit (10 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 8: FIFO entries. Must be a power of two, ≥ 2.
- `wb_clk_i` input 1: the only clock.
- `wb_rst_i` input 1: reset, synchronous and active-high.
- `rx` input 1: raw serial input from `io_in`, asynchronous, idle high.
- `rx_data` output 8: FIFO head byte, valid while `rx_valid`=1.
- `rx_valid` output 1: FIFO non-empty.
- `rx_ready` input 1: consumer pops the head when `rx_valid & rx_ready`.
- `rx_count` output $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `frame_err` output 1: 1-cycle pulse; stop bit sampled 0.
- `overrun_err` output 1: 1-cycle pulse; good byte dropped because the FIFO was full.
- `parity_err` output 1: 1-cycle pulse; parity mismatch. Constant 0 without `UART_RX_PARITY_EN`.
- `irq` output 1: equals `rx_valid`, routed to `user_irq[0]`.

## Operation
- **Synchroniser:** `rx` passes through a 2-flop synchroniser to give `rx_s`. Both flops reset to 1.
- **Bit timer:** a down-counter that reloads on each state change.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE: when `rx_s`=0, go to START and load the timer with `CLK_PER_BIT/2 - 1`.
  - START: when the timer expires, sample `rx_s`.
    - If 1, treat it as a glitch and go to IDLE.
    - If 0, go to DATA, set bit index 0, and load `CLK_PER_BIT - 1`.
  - DATA: each expiry shifts `rx_s` into the shift register, LSB first. After bit 7, go to PARITY (or to STOP without the macro).
  - PARITY: on expiry, compare the sampled bit with the XOR of the 8 data bits (even parity), then go to STOP.
  - STOP: on expiry, sample `rx_s`.
    - If 1 and parity is OK, push the byte and go to IDLE.
    - If 1 and parity is bad, pulse `parity_err`, discard the byte, and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- **FIFO behaviour:**
  - Circular buffer with read and write pointers, wrapping modulo `FIFO_DEPTH`.
  - `rx_data` is driven from the head entry (fall-through).
  - Push when not full: store the byte and increment the count.
  - Push when full with no pop: drop the byte, pulse `overrun_err`, leave the FIFO unchanged.
  - Push and pop in the same cycle: both are performed and the count is unchanged. This holds even when full; no overrun occurs.
  - Pop when empty is ignored.
- **Reset:** reset mid-frame discards any partial byte, empties the FIFO, and returns to IDLE.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `rx_count`=0, `irq`=0.
  - All error pulses 0.
  - FSM in IDLE; synchroniser flops 1.
- Let t0 be the first cycle in which `rx_s`=0. This is 2 to 3 cycles after the pad edge.
  - Start-bit sample: t0 + `CLK_PER_BIT/2`.
  - Data bit i sample: t0 + `CLK_PER_BIT/2` + (i+1)·`CLK_PER_BIT`.
  - Stop-bit sample: t0 + `CLK_PER_BIT/2` + 9·`CLK_PER_BIT`. Add one more `CLK_PER_BIT` with parity.
- `rx_valid`, `rx_count` and the `rx_data` update appear in the cycle after the stop sample. The error pulses also appear in that cycle.
- The FSM is back in IDLE in the cycle after the stop sample. Back-to-back frames with no idle gap are received without loss.
- A pop takes effect on the clock edge. The next head byte and the decremented count are visible in the following cycle.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined: 8E1 frames. The PARITY state is present and `parity_err` is active. Bytes with a parity error are discarded.
- Undefined: 8N1 frames. The PARITY state is removed and `parity_err` is tied to 0. A 10th bit on the line is sampled as the stop bit.

## Test plan
All scenarios use `CLK_PER_BIT`=16 and `FIFO_DEPTH`=8 unless stated.
- **Single byte:** send 0xA5 (8N1) with `rx_ready`=0.
  - `rx_valid` rises at t0+153.
  - `rx_data`=0xA5, `rx_count`=1, `irq`=1.
  - One pop returns the count to 0.
- **Glitch:** drive `rx` low for 6 cycles, then high.
  - No push, no error pulse.
  - FSM back in IDLE.
  - A following 0x3C frame is received correctly.
- **Framing error and break:** send 0x81 with stop bit 0, then hold `rx` low for 40 bit times.
  - Exactly one `frame_err` pulse and no push.
  - After `rx` returns high, a 0x55 frame is received correctly.
- **Overrun:** send 9 bytes 0x00..0x08 back-to-back with `rx_ready`=0.
  - `rx_count`=8.
  - One `overrun_err` pulse on the 9th byte.
  - Popping returns 0x00..0x07 in order.
- **Full FIFO with simultaneous pop:** with the FIFO full, pop in the push cycle of byte 0x99.
  - No overrun; `rx_count` stays 8.
  - 0x99 is the last byte read out.
- **Parity (`UART_RX_PARITY_EN` defined):** send 0x03 with parity bit 1.
  - `parity_err` pulses and nothing is pushed.
  - Sending 0x03 with parity bit 0 pushes 0x03.
